// File: rtl/memory_bank_responder.sv
// Single-port SRAM bank below the memory arbiter: zero-fills after reset, then serves
// one access per cycle with a pipelined read response. NPU_MEM_PARITY_EN adds per-word parity.
module memory_bank_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_we,
  input  logic                  mem_ce,
`ifdef NPU_MEM_PARITY_EN
  input  logic                  mem_perr_inject,
  output logic                  mem_perr,
`endif
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rvalid,
  output logic                  mem_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    accept_c;
  logic                    in_range_c;
  logic [DEPTH_LOG2-1:0]   idx_c;
  logic                    wr_en_c;
  logic [DEPTH_LOG2-1:0]   wr_idx_c;
  logic [DATA_WIDTH-1:0]   wr_data_c;

  // Read pipeline: valid bits carry reset, data stages do not need it.
  logic [RD_LATENCY-1:0]   pipe_vld;
  logic [DATA_WIDTH-1:0]   pipe_data [RD_LATENCY];

  // An access is only accepted once initialisation has completed.
  assign accept_c   = mem_ce & mem_ready & ~rst;
  assign in_range_c = (mem_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
  assign idx_c      = mem_addr[DEPTH_LOG2-1:0];
  assign wr_en_c    = ~rst & ((state == ST_INIT) | (accept_c & mem_we & in_range_c));
  assign wr_idx_c   = (state == ST_INIT) ? init_cnt : idx_c;
  assign wr_data_c  = (state == ST_INIT) ? '0 : mem_wdata;

`ifdef NPU_MEM_PARITY_EN
  logic                  par [DEPTH];
  logic                  wr_par_c;
  logic [RD_LATENCY-1:0] pipe_pm;

  // Even parity over the data word; inject flips the stored bit.
  assign wr_par_c = (state == ST_INIT) ? 1'b0 : ((^mem_wdata) ^ mem_perr_inject);

  always_ff @(posedge clk) begin
    if (wr_en_c) par[wr_idx_c] <= wr_par_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_pm  <= '0;
      mem_perr <= 1'b0;
    end else begin
      pipe_pm[0] <= in_range_c & ((^mem[idx_c]) ^ par[idx_c]);
      for (int i = 1; i < int'(RD_LATENCY); i++) pipe_pm[i] <= pipe_pm[i-1];
      mem_perr <= pipe_vld[RD_LATENCY-1] & pipe_pm[RD_LATENCY-1];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_idx_c] <= wr_data_c;
  end

  // Out-of-range reads travel the pipeline as zero data.
  always_ff @(posedge clk) begin
    pipe_data[0] <= in_range_c ? mem[idx_c] : '0;
    for (int i = 1; i < int'(RD_LATENCY); i++) pipe_data[i] <= pipe_data[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      mem_ready  <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      mem_err    <= 1'b0;
      pipe_vld   <= '0;
    end else begin
      mem_err     <= accept_c & ~in_range_c;
      pipe_vld[0] <= accept_c & ~mem_we;
      for (int i = 1; i < int'(RD_LATENCY); i++) pipe_vld[i] <= pipe_vld[i-1];
      mem_rvalid  <= pipe_vld[RD_LATENCY-1];
      if (pipe_vld[RD_LATENCY-1]) mem_rdata <= pipe_data[RD_LATENCY-1];

      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + DEPTH_LOG2'(1);
          if (&init_cnt) begin
            state     <= ST_READY;
            mem_ready <= 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bank_responder.sv
// Directed self-checking bench for memory_bank_responder (RD_LATENCY = 2, depth 1024).
module tb_memory_bank_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ce;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_err;
`ifdef NPU_MEM_PARITY_EN
  logic        mem_perr_inject;
  logic        mem_perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  memory_bank_responder dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_ce     (mem_ce),
`ifdef NPU_MEM_PARITY_EN
    .mem_perr_inject(mem_perr_inject),
    .mem_perr   (mem_perr),
`endif
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_ce = 1'b0; mem_we = 1'b0;
  endtask

  // Issue one read and return after the edge where its rvalid strobe appears.
  task automatic do_read(input string tag, input logic [15:0] a, input logic [31:0] exp);
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = a;
    tick();
    mem_ce = 1'b0;
    tick();
    check({tag, "_early_rvalid"}, 32'(mem_rvalid), 32'd0);
    tick();
    check({tag, "_rvalid"}, 32'(mem_rvalid), 32'd1);
    check({tag, "_rdata"}, mem_rdata, exp);
  endtask

  // Count edges from rst deassertion until mem_ready, watching for stray rvalid.
  task automatic wait_ready(input string tag);
    int n = 0;
    int stray = 0;
    while (mem_ready !== 1'b1 && n < 1100) begin
      tick();
      n++;
      if (mem_rvalid !== 1'b0 || mem_err !== 1'b0) stray++;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd1024);
    check({tag, "_stray_strobes"}, 32'(stray), 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_ce = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
`ifdef NPU_MEM_PARITY_EN
    mem_perr_inject = 1'b0;
`endif
    tick();
    check("rst_ready",  32'(mem_ready),  32'd0);
    check("rst_rvalid", 32'(mem_rvalid), 32'd0);
    check("rst_rdata",  mem_rdata,       32'd0);
    check("rst_err",    32'(mem_err),    32'd0);

    // Reads requested all through init are ignored.
    rst = 1'b0; mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 16'h0005;
    wait_ready("init1");
    tick();
    mem_ce = 1'b0;
    tick();
    check("first_read_early", 32'(mem_rvalid), 32'd0);
    tick();
    check("first_read_rvalid", 32'(mem_rvalid), 32'd1);
    check("first_read_rdata",  mem_rdata,       32'd0);
    tick();
    check("first_read_strobe_end", 32'(mem_rvalid), 32'd0);

    // Write followed immediately by read of the same word.
    do_write(16'h0010, 32'hDEADBEEF);
    do_read("wr_rd", 16'h0010, 32'hDEADBEEF);

    // Back-to-back reads give consecutive in-order strobes.
    do_write(16'h0001, 32'h11);
    do_write(16'h0002, 32'h22);
    do_write(16'h0003, 32'h33);
    mem_ce = 1'b1; mem_we = 1'b0;
    mem_addr = 16'h0001; tick();
    mem_addr = 16'h0002; tick();
    mem_addr = 16'h0003; tick();
    mem_ce = 1'b0;
    check("b2b_v1", 32'(mem_rvalid), 32'd1);
    check("b2b_d1", mem_rdata, 32'h11);
    tick();
    check("b2b_v2", 32'(mem_rvalid), 32'd1);
    check("b2b_d2", mem_rdata, 32'h22);
    tick();
    check("b2b_v3", 32'(mem_rvalid), 32'd1);
    check("b2b_d3", mem_rdata, 32'h33);
    tick();
    check("b2b_done", 32'(mem_rvalid), 32'd0);
    check("rdata_hold", mem_rdata, 32'h33);

    // Out-of-range write errors and must not alias onto word 0.
    do_write(16'h0400, 32'h12345678);
    check("oor_wr_err", 32'(mem_err), 32'd1);
    tick();
    check("oor_wr_err_end", 32'(mem_err), 32'd0);
    do_read("alias0", 16'h0000, 32'd0);
    do_read("pre_oor", 16'h0010, 32'hDEADBEEF);
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 16'h0400;
    tick();
    mem_ce = 1'b0;
    check("oor_rd_err", 32'(mem_err), 32'd1);
    tick();
    check("oor_rd_err_end", 32'(mem_err), 32'd0);
    tick();
    check("oor_rd_rvalid", 32'(mem_rvalid), 32'd1);
    check("oor_rd_rdata",  mem_rdata,       32'd0);

    // Reset with a read in flight: no response, contents re-zeroed.
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
    tick();
    mem_ce = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready",  32'(mem_ready),  32'd0);
    check("mid_rst_rvalid", 32'(mem_rvalid), 32'd0);
    check("mid_rst_rdata",  mem_rdata,       32'd0);
    wait_ready("init2");
    do_read("rezero", 16'h0010, 32'd0);

`ifdef NPU_MEM_PARITY_EN
    mem_perr_inject = 1'b1;
    do_write(16'h0020, 32'h000000A5);
    mem_perr_inject = 1'b0;
    do_read("par_inj", 16'h0020, 32'h000000A5);
    check("par_inj_perr", 32'(mem_perr), 32'd1);
    do_write(16'h0020, 32'h000000A5);
    do_read("par_ok", 16'h0020, 32'h000000A5);
    check("par_ok_perr", 32'(mem_perr), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
